// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounces start/lap buttons, turns presses into events and runs the stopwatch mode FSM
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       lap_btn,
  output logic       run_en,
  output logic       lap_freeze,
  output logic       clear,
  output logic [1:0] mode
);
  if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_param
    $error("DEBOUNCE_CYCLES must be in 1 .. 2**CNT_W-1");
  end
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STOP = 2'b10, LAP = 2'b11} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [1:0] s1, s2, deb, deb_d, press;
  logic [CNT_W-1:0] cnt [2];
  state_t state, nxt;
  logic clr_q;
  // bit 0 is start, bit 1 is lap
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      deb <= '0;
      deb_d <= '0;
      press <= '0;
      cnt <= '{default: '0};
    end else begin
      s1 <= {lap_btn, start_btn};
      s2 <= s1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == LAST) begin
          cnt[i] <= '0;
          deb[i] <= ~deb[i];
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      clr_q <= 1'b0;
    end else begin
      state <= nxt;
      clr_q <= state == STOP && nxt == IDLE;
    end
  end
  // start is tested first everywhere, so a simultaneous lap press is dropped
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = press[0] ? RUN : IDLE;
      RUN:  nxt = press[0] ? STOP : press[1] ? LAP : RUN;
      LAP:  nxt = press[0] ? STOP : press[1] ? RUN : LAP;
      STOP: nxt = press[0] ? RUN : press[1] ? IDLE : STOP;
    endcase
  end
  always_comb begin
    mode = state;
    run_en = state == RUN || state == LAP;
    lap_freeze = state == LAP;
    clear = clr_q;
  end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: window-based behavioural model checked every cycle plus directed literal checks
module tb_stopwatch_ctrl;
  localparam int D = 4;
  logic clk = 0, reset = 1, start_btn = 0, lap_btn = 0;
  logic run_en, lap_freeze, clear;
  logic [1:0] mode;
  int total = 0, bad = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .lap_btn(lap_btn),
    .run_en(run_en), .lap_freeze(lap_freeze), .clear(clear), .mode(mode)
  );

  always #5 clk = ~clk;

  // model: a level is accepted once the synchronised pin has sat at the other level for D straight cycles
  bit hs[$], hl[$];
  bit md_s, md_l, mo_s, mo_l, mp_s, mp_l, mc, armed;
  logic [1:0] mm;

  function automatic logic [1:0] step(input logic [1:0] m, input bit s, input bit l);
    if (s) return (m == 2'd0 || m == 2'd2) ? 2'd1 : 2'd2;
    if (l) return m == 2'd1 ? 2'd3 : m == 2'd3 ? 2'd1 : m == 2'd2 ? 2'd0 : m;
    return m;
  endfunction

  function automatic bit held(input bit q[$], input bit lvl);
    for (int i = 0; i < D; i++) if (q[i] != lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      hs = {};
      hl = {};
      for (int i = 0; i <= D; i++) begin
        hs.push_back(1'b0);
        hl.push_back(1'b0);
      end
      {md_s, md_l, mo_s, mo_l, mp_s, mp_l, mc} = '0;
      mm = 2'd0;
      armed = 1'b1;
    end else begin
      mc = mm == 2'd2 && step(mm, mp_s, mp_l) == 2'd0;
      mm = step(mm, mp_s, mp_l);
      mp_s = md_s & ~mo_s;
      mp_l = md_l & ~mo_l;
      mo_s = md_s;
      mo_l = md_l;
      if (held(hs, ~md_s)) md_s = ~md_s;
      if (held(hl, ~md_l)) md_l = ~md_l;
      hs.push_back(start_btn);
      hl.push_back(lap_btn);
      void'(hs.pop_front());
      void'(hl.pop_front());
    end
  end

  task automatic chk(input string n, input logic [1:0] a, input logic [1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) if (armed) begin
    chk("model mode", mode, mm);
    chk("model run_en", {1'b0, run_en}, {1'b0, mm == 2'd1 || mm == 2'd3});
    chk("model lap_freeze", {1'b0, lap_freeze}, {1'b0, mm == 2'd3});
    chk("model clear", {1'b0, clear}, {1'b0, mc});
  end

  task automatic pulse(input bit lap, input int hi, input int lo);
    @(negedge clk);
    if (lap) lap_btn = 1; else start_btn = 1;
    repeat (hi) @(negedge clk);
    if (lap) lap_btn = 0; else start_btn = 0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset mode", mode, 2'd0);
    chk("reset run_en", {1'b0, run_en}, 2'd0);
    chk("reset lap_freeze", {1'b0, lap_freeze}, 2'd0);
    chk("reset clear", {1'b0, clear}, 2'd0);
    reset = 0;
    // bounce: 1,2,3-cycle highs separated by single lows
    pulse(0, 1, 1);
    pulse(0, 2, 1);
    pulse(0, 3, 20);
    chk("bounce mode", mode, 2'd0);
    chk("bounce run_en", {1'b0, run_en}, 2'd0);
    // clean press: run_en rises on the 8th edge
    @(negedge clk);
    start_btn = 1;
    repeat (7) @(negedge clk);
    chk("press edge7 run_en", {1'b0, run_en}, 2'd0);
    @(negedge clk);
    chk("press edge8 run_en", {1'b0, run_en}, 2'd1);
    chk("press edge8 mode", mode, 2'd1);
    repeat (12) @(negedge clk);
    start_btn = 0;
    repeat (20) @(negedge clk);
    chk("hold one event mode", mode, 2'd1);
    // lap in and out
    pulse(1, 10, 10);
    chk("lap mode", mode, 2'd3);
    chk("lap freeze", {1'b0, lap_freeze}, 2'd1);
    chk("lap run_en", {1'b0, run_en}, 2'd1);
    pulse(1, 10, 10);
    chk("lap release mode", mode, 2'd1);
    chk("lap release freeze", {1'b0, lap_freeze}, 2'd0);
    // stop then clear
    pulse(0, 10, 10);
    chk("stop mode", mode, 2'd2);
    chk("stop run_en", {1'b0, run_en}, 2'd0);
    @(negedge clk);
    lap_btn = 1;
    repeat (7) @(negedge clk);
    chk("clear edge7", {1'b0, clear}, 2'd0);
    @(negedge clk);
    chk("clear edge8", {1'b0, clear}, 2'd1);
    chk("clear edge8 mode", mode, 2'd0);
    @(negedge clk);
    chk("clear edge9", {1'b0, clear}, 2'd0);
    repeat (7) @(negedge clk);
    lap_btn = 0;
    repeat (15) @(negedge clk);
    // simultaneous presses in RUN: start wins
    pulse(0, 10, 10);
    chk("rerun mode", mode, 2'd1);
    @(negedge clk);
    start_btn = 1;
    lap_btn = 1;
    repeat (10) @(negedge clk);
    start_btn = 0;
    lap_btn = 0;
    repeat (15) @(negedge clk);
    chk("both mode", mode, 2'd2);
    chk("both freeze", {1'b0, lap_freeze}, 2'd0);
    // reset mid-press with start held
    pulse(0, 10, 10);
    chk("resume mode", mode, 2'd1);
    @(negedge clk);
    start_btn = 1;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("midreset mode", mode, 2'd0);
    reset = 0;
    repeat (7) @(negedge clk);
    chk("post reset edge7 mode", mode, 2'd0);
    @(negedge clk);
    chk("post reset edge8 mode", mode, 2'd1);
    repeat (10) @(negedge clk);
    start_btn = 0;
    repeat (15) @(negedge clk);
    chk("post reset final mode", mode, 2'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
